// File: rtl/mem_stage_pipe.sv
// EXE->MEM pipeline register plus data_sram response tracking for the MEM stage.
// Optional one-entry response buffer, enabled by defining MEM_RESP_BUFFER_EN.
module mem_stage_pipe #(
  parameter int BUS_W           = 150,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              exe_ready_go,
  input  logic [BUS_W-1:0]  exe_to_mem_bus,
  input  logic              exe_mem_req,
  input  logic              exe_req_pending,
  input  logic              wb_allow_in,
  input  logic              flush,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_allow_in,
  output logic              mem_valid,
  output logic              mem_ready_go,
  output logic              mem_to_wb_valid,
  output logic [BUS_W-1:0]  mem_bus,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             wait_resp;
  logic [CNT_W-1:0] cancel_cnt;
  logic [CNT_W-1:0] cancel_nxt;
  logic             resp_hit;
  logic             resp_accept;
  logic             capture;

  // A response while cancels are owed always belongs to a killed instruction.
  assign resp_hit    = data_sram_data_ok && (cancel_cnt == '0);
  assign resp_accept = resp_hit && wait_resp;

  assign mem_allow_in    = !mem_valid || (mem_ready_go && wb_allow_in);
  assign mem_to_wb_valid = mem_valid && mem_ready_go;
  assign capture         = exe_valid && exe_ready_go && mem_allow_in && !flush;

`ifdef MEM_RESP_BUFFER_EN
  logic              buf_valid;
  logic [DATA_W-1:0] rdata_buf;

  assign mem_ready_go = mem_valid && (!wait_resp || buf_valid || resp_hit);
  assign mem_rdata    = buf_valid ? rdata_buf : data_sram_rdata;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      buf_valid <= 1'b0;
    end else if (mem_to_wb_valid && wb_allow_in) begin
      buf_valid <= 1'b0;
    end else if (resp_accept && !wb_allow_in) begin
      buf_valid <= 1'b1;
    end
  end

  // NOTE: pure data register, qualified by buf_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (resp_accept && !wb_allow_in) begin
      rdata_buf <= data_sram_rdata;
    end
  end
`else
  assign mem_ready_go = mem_valid && (!wait_resp || resp_hit);
  assign mem_rdata    = data_sram_rdata;
`endif

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    cancel_nxt = cancel_cnt;
    if (flush && mem_valid && wait_resp && !resp_accept) begin
      cancel_nxt = cancel_nxt + CNT_ONE;
    end
    if (flush && exe_req_pending) begin
      cancel_nxt = cancel_nxt + CNT_ONE;
    end
    if (data_sram_data_ok && (cancel_cnt != '0)) begin
      cancel_nxt = cancel_nxt - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      wait_resp  <= 1'b0;
      cancel_cnt <= '0;
      mem_bus    <= '0;
    end else begin
      cancel_cnt <= cancel_nxt;
      if (capture) begin
        mem_bus <= exe_to_mem_bus;
      end
      if (flush) begin
        mem_valid <= 1'b0;
      end else if (mem_allow_in) begin
        mem_valid <= exe_valid && exe_ready_go;
      end
      // On flush the outstanding response is handed to the cancel counter.
      if (flush) begin
        wait_resp <= 1'b0;
      end else if (capture) begin
        wait_resp <= exe_mem_req;
      end else if (resp_accept) begin
        wait_resp <= 1'b0;
      end
    end
  end

endmodule
